// File: rtl/filter_core_7x7.sv
// 7x7 raster window generator.
// Six cascaded line memories feed a 7x7 shift window.
module filter_core_7x7 #(
  parameter int DE_I_PERIOD   = 0,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] x00, x01, x02, x03, x04, x05, x06,
  output logic [DATA_WIDTH-1:0] x07, x08, x09, x10, x11, x12, x13,
  output logic [DATA_WIDTH-1:0] x14, x15, x16, x17, x18, x19, x20,
  output logic [DATA_WIDTH-1:0] x21, x22, x23, x24, x25, x26, x27,
  output logic [DATA_WIDTH-1:0] x28, x29, x30, x31, x32, x33, x34,
  output logic [DATA_WIDTH-1:0] x35, x36, x37, x38, x39, x40, x41,
  output logic [DATA_WIDTH-1:0] x42, x43, x44, x45, x46, x47, x48,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  if (DE_I_PERIOD != 0 && DE_I_PERIOD != 2 && DE_I_PERIOD != 4)
  begin : g_bad_period
    $error("DE_I_PERIOD must be 0, 2 or 4");
  end

  logic [AW-1:0] col_q, col_d;
  logic [2:0]    row_q, row_d;
  logic          seen_q, seen_d;
  logic          arm_q, arm_d;
  logic          hs_prev_q;
  logic          vld1_d;

  logic          de1_q, vld1_q, byp1_q, hs1_q, vs1_q;
  pix_t          di1_q;
  pix_t          rd_q [6];
  pix_t          lb_q [6][LINE_SIZE_MAX];

  pix_t          win_q [7][7];
  pix_t          win_d [7][7];
  logic          de_q, hs_q, vs_q;

  // Raster position; row only counts once a line has fully gone by
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    seen_d = seen_q;
    arm_d  = arm_q | ~vs_i;
    if (hs_i) begin
      col_d = '0;
    end else if (de_i) begin
      if (col_q == AW'(LINE_SIZE_MAX - 1))
        col_d = '0;
      else
        col_d = col_q + 1'b1;
    end
    if (!vs_i) begin
      row_d  = '0;
      seen_d = 1'b0;
    end else if (hs_prev_q && !hs_i) begin
      seen_d = 1'b1;
      if (seen_q && row_q != 3'd6)
        row_d = row_q + 3'd1;
    end
    vld1_d = de_i & (bypass |
             (arm_d & (row_d == 3'd6) & (col_q >= AW'(6))));
  end

  // Cascaded line memories, read-before-write shifts lines down
  always_ff @(posedge clk) begin
    if (de_i) begin
      lb_q[0][col_q] <= di_i;
      rd_q[0]        <= lb_q[0][col_q];
      for (int k = 1; k < 6; k++) begin
        lb_q[k][col_q] <= lb_q[k-1][col_q];
        rd_q[k]        <= lb_q[k][col_q];
      end
    end
  end

  // Window shifts left one column per pixel; bypass steers x24
  always_comb begin
    win_d = win_q;
    if (de1_q) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 6; c++)
          win_d[r][c] = win_q[r][c+1];
      for (int r = 0; r < 6; r++)
        win_d[r][6] = rd_q[5-r];
      win_d[6][6] = di1_q;
      if (byp1_q)
        win_d[3][3] = di1_q;
    end
  end

  // Counters, stage-1 strobes and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      seen_q    <= 1'b0;
      arm_q     <= 1'b0;
      hs_prev_q <= 1'b1;
      de1_q     <= 1'b0;
      vld1_q    <= 1'b0;
      byp1_q    <= 1'b0;
      di1_q     <= '0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b0;
      win_q     <= '{default: '0};
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      seen_q    <= seen_d;
      arm_q     <= arm_d;
      hs_prev_q <= hs_i;
      de1_q     <= de_i;
      vld1_q    <= vld1_d;
      byp1_q    <= bypass;
      di1_q     <= di_i;
      hs1_q     <= hs_i;
      vs1_q     <= vs_i;
      win_q     <= win_d;
      de_q      <= vld1_q;
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
    end
  end

  assign de_o = de_q;
  assign hs_o = hs_q;
  assign vs_o = vs_q;

  assign x00 = win_q[0][0]; assign x01 = win_q[0][1];
  assign x02 = win_q[0][2]; assign x03 = win_q[0][3];
  assign x04 = win_q[0][4]; assign x05 = win_q[0][5];
  assign x06 = win_q[0][6];
  assign x07 = win_q[1][0]; assign x08 = win_q[1][1];
  assign x09 = win_q[1][2]; assign x10 = win_q[1][3];
  assign x11 = win_q[1][4]; assign x12 = win_q[1][5];
  assign x13 = win_q[1][6];
  assign x14 = win_q[2][0]; assign x15 = win_q[2][1];
  assign x16 = win_q[2][2]; assign x17 = win_q[2][3];
  assign x18 = win_q[2][4]; assign x19 = win_q[2][5];
  assign x20 = win_q[2][6];
  assign x21 = win_q[3][0]; assign x22 = win_q[3][1];
  assign x23 = win_q[3][2]; assign x24 = win_q[3][3];
  assign x25 = win_q[3][4]; assign x26 = win_q[3][5];
  assign x27 = win_q[3][6];
  assign x28 = win_q[4][0]; assign x29 = win_q[4][1];
  assign x30 = win_q[4][2]; assign x31 = win_q[4][3];
  assign x32 = win_q[4][4]; assign x33 = win_q[4][5];
  assign x34 = win_q[4][6];
  assign x35 = win_q[5][0]; assign x36 = win_q[5][1];
  assign x37 = win_q[5][2]; assign x38 = win_q[5][3];
  assign x39 = win_q[5][4]; assign x40 = win_q[5][5];
  assign x41 = win_q[5][6];
  assign x42 = win_q[6][0]; assign x43 = win_q[6][1];
  assign x44 = win_q[6][2]; assign x45 = win_q[6][3];
  assign x46 = win_q[6][4]; assign x47 = win_q[6][5];
  assign x48 = win_q[6][6];

endmodule

// File: tb/tb_filter_core_7x7.sv
// Bench for filter_core_7x7.
// Frame-store model predicts every output two clocks after input.
module tb_filter_core_7x7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bypass = 1'b0;
  logic       de_i = 1'b0;
  logic       hs_i = 1'b1;
  logic       vs_i = 1'b0;
  logic [7:0] di_i = '0;
  logic [7:0] xo [49];
  logic       de_o, hs_o, vs_o;

  always #5 clk = ~clk;

  filter_core_7x7 #(
    .DE_I_PERIOD(0), .LINE_SIZE_MAX(4096), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .bypass(bypass),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .x00(xo[0]),  .x01(xo[1]),  .x02(xo[2]),  .x03(xo[3]),
    .x04(xo[4]),  .x05(xo[5]),  .x06(xo[6]),  .x07(xo[7]),
    .x08(xo[8]),  .x09(xo[9]),  .x10(xo[10]), .x11(xo[11]),
    .x12(xo[12]), .x13(xo[13]), .x14(xo[14]), .x15(xo[15]),
    .x16(xo[16]), .x17(xo[17]), .x18(xo[18]), .x19(xo[19]),
    .x20(xo[20]), .x21(xo[21]), .x22(xo[22]), .x23(xo[23]),
    .x24(xo[24]), .x25(xo[25]), .x26(xo[26]), .x27(xo[27]),
    .x28(xo[28]), .x29(xo[29]), .x30(xo[30]), .x31(xo[31]),
    .x32(xo[32]), .x33(xo[33]), .x34(xo[34]), .x35(xo[35]),
    .x36(xo[36]), .x37(xo[37]), .x38(xo[38]), .x39(xo[39]),
    .x40(xo[40]), .x41(xo[41]), .x42(xo[42]), .x43(xo[43]),
    .x44(xo[44]), .x45(xo[45]), .x46(xo[46]), .x47(xo[47]),
    .x48(xo[48]),
    .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  typedef struct {
    bit         rst, de, hs, vs, byp, clean;
    int         x, y;
    logic [7:0] di;
    logic [7:0] w [49];
  } rec_t;

  rec_t       h0, h1;
  logic [7:0] fr [32][32];
  int         cur_x = 0, cur_y = 0;
  bit         cur_clean = 1'b0;
  int         n_cmp = 0, n_bad = 0, de_cnt = 0;
  bit         got_first = 1'b0;
  logic [7:0] fw [49];
  int         fx = -1, fy = -1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Record each sampled input with the window it must produce
  always @(posedge clk) begin
    rec_t r;
    r.rst = rst; r.de = de_i; r.hs = hs_i; r.vs = vs_i;
    r.byp = bypass; r.clean = cur_clean;
    r.x = cur_x; r.y = cur_y; r.di = di_i;
    for (int k = 0; k < 49; k++) r.w[k] = '0;
    if (de_i && cur_x >= 6 && cur_y >= 6)
      for (int k = 0; k < 49; k++)
        r.w[k] = fr[cur_y - 6 + k / 7][cur_x - 6 + k % 7];
    h1 <= h0;
    h0 <= r;
  end

  // Compare outputs against the record from two clocks earlier
  always @(negedge clk) begin
    bit ed;
    int eh, ev, bk;
    if (rst) begin
      chk("rst_de", de_o, 0);
      chk("rst_hs", hs_o, 1);
      chk("rst_vs", vs_o, 0);
      bk = -1;
      for (int k = 0; k < 49; k++)
        if (bk < 0 && xo[k] != 8'd0) bk = k;
      if (bk < 0) bk = 0;
      chk($sformatf("rst_x%0d", bk), xo[bk], 0);
    end else begin
      ed = !h1.rst && h1.de &&
           (h1.byp || (h1.clean && h1.x >= 6 && h1.y >= 6));
      eh = h1.rst ? 1 : int'(h1.hs);
      ev = h1.rst ? 0 : int'(h1.vs);
      chk("de_o", de_o, ed);
      chk("hs_o", hs_o, eh);
      chk("vs_o", vs_o, ev);
      if (de_o) de_cnt++;
      if (ed && de_o) begin
        if (h1.byp) begin
          chk("byp_x24", xo[24], h1.di);
        end else begin
          bk = -1;
          for (int k = 0; k < 49; k++)
            if (bk < 0 && xo[k] != h1.w[k]) bk = k;
          if (bk < 0) bk = 24;
          chk($sformatf("win_x%0d", bk), xo[bk], h1.w[bk]);
        end
        if (!got_first) begin
          got_first = 1'b1;
          fx = h1.x;
          fy = h1.y;
          for (int k = 0; k < 49; k++) fw[k] = xo[k];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pv(int mode, int x, int y);
    case (mode)
      0:       return 8'(x);
      1:       return 8'(24 * y + x);
      default: return 8'($urandom);
    endcase
  endfunction

  // 24x24 frame; rst_y >= 0 pulses reset at x=5 of that line
  task automatic run_frame(int per, bit byp, int mode, int rst_y);
    logic [7:0] v;
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0; bypass = byp;
    repeat (4) cyc();
    cur_clean = 1'b1; de_cnt = 0; got_first = 1'b0;
    fx = -1; fy = -1;
    vs_i = 1'b1;
    repeat (3) cyc();
    for (int y = 0; y < 24; y++) begin
      hs_i = 1'b0;
      for (int x = 0; x < 24; x++) begin
        if (y == rst_y && x == 5) begin
          de_i = 1'b0;
          rst = 1'b1;
          repeat (3) cyc();
          rst = 1'b0;
          cur_clean = 1'b0;
        end
        v = pv(mode, x, y);
        fr[y][x] = v;
        di_i = v; de_i = 1'b1;
        cur_x = x; cur_y = y;
        cyc();
        if (per > 0) begin
          de_i = 1'b0;
          repeat (per - 1) cyc();
        end
      end
      de_i = 1'b0; hs_i = 1'b1;
      repeat (4) cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    run_frame(0, 1'b0, 0, -1);
    chk("f1_cnt", de_cnt, 324);
    chk("f1_fx", fx, 6);
    chk("f1_fy", fy, 6);
    chk("f1_x00", fw[0], 0);
    chk("f1_x06", fw[6], 6);
    chk("f1_x42", fw[42], 0);
    chk("f1_x48", fw[48], 6);
    chk("f1_x24", fw[24], 3);

    run_frame(0, 1'b0, 1, -1);
    chk("f2_cnt", de_cnt, 324);
    chk("f2_x00", fw[0], 0);
    chk("f2_x06", fw[6], 6);
    chk("f2_x42", fw[42], 144);
    chk("f2_x48", fw[48], 150);
    chk("f2_x24", fw[24], 75);

    run_frame(2, 1'b0, 0, -1);
    chk("p2_cnt", de_cnt, 324);
    chk("p2_x06", fw[6], 6);
    chk("p2_x45", fw[45], 3);

    run_frame(4, 1'b0, 0, -1);
    chk("p4_cnt", de_cnt, 324);
    chk("p4_x48", fw[48], 6);

    run_frame(0, 1'b0, 2, -1);
    chk("rnd_cnt", de_cnt, 324);
    chk("rnd_fx", fx, 6);
    chk("rnd_fy", fy, 6);

    run_frame(0, 1'b1, 2, -1);
    chk("byp_cnt", de_cnt, 576);

    run_frame(0, 1'b0, 0, 8);
    chk("mrst_cnt", de_cnt, 36);

    run_frame(0, 1'b0, 0, -1);
    chk("post_cnt", de_cnt, 324);
    chk("post_fy", fy, 6);
    chk("post_x24", fw[24], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_core_7x7.md
Name: filter_core_7x7

Overview:
- Streaming 7x7 neighbourhood (window) generator for raster video.
- Buffers the six previous lines in on-chip line memories and presents all 49 pixels of the current 7x7 window in parallel, aligned with delayed sync/valid strobes.
- Sits in front of 7x7 spatial filters (median, convolution, morphology), which consume x00..x48.

Parameters:
- DE_I_PERIOD, 0, input pixel cadence: 0 = de_i may be high every clock, 2 = at most one pixel every 2 clocks, 4 = one every 4. Function and latency are identical for all legal values (0, 2, 4); only the sustained throughput demand differs.
- LINE_SIZE_MAX, 4096, maximum active pixels per line; sets depth of each line memory.
- DATA_WIDTH, 8, bits per pixel.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bypass  in  1  1 = pass-through mode (see Behaviour).
- di_i  in  DATA_WIDTH  input pixel, valid when de_i=1.
- de_i  in  1  input pixel valid.
- hs_i  in  1  line blanking, high between lines, low during active line.
- vs_i  in  1  frame active, high for whole frame, low in vertical blanking.
- x00..x48  out  DATA_WIDTH each  window pixels, row-major: x(7r+c), r = 0..6 (oldest line first), c = 0..6 (oldest column first).
- de_o  out  1  window valid.
- hs_o  out  1  hs_i delayed by the pipeline latency.
- vs_o  out  1  vs_i delayed by the pipeline latency.

Behaviour:
- Column counter col: increments on each de_i. Cleared while hs_i=1. Serves as the line-memory address.
- Line counter row:
  - increments on the falling edge of hs_i (start of each line) while vs_i=1;
  - cleared while vs_i=0;
  - saturates at 6.
- Line memories:
  - 6 cascaded memories LB1..LB6, each LINE_SIZE_MAX x DATA_WIDTH.
  - On de_i at address col: read LBk[col], write LB1[col] <= di_i, LBk+1[col] <= old LBk[col].
  - Memory contents are not reset.
- Window registers:
  - 7 rows x 7 columns shift left by one column on each de_i.
  - The new right column (c = 6) loads: row 6 <= di_i, row 5 <= LB1, ..., row 0 <= LB6.
  - For input pixel P(x,y) at de_i: x(7r+c) = P(x-6+c, y-6+r). So x48 = P(x,y), x00 = P(x-6,y-6), x24 = P(x-3,y-3) (centre).
- Latency: window outputs, de_o, hs_o and vs_o all appear exactly 2 clk after the de_i/hs_i/vs_i sample that produced them. This covers one memory read cycle plus one output register.
- Normal mode (bypass=0):
  - de_o = 1 only for pixels with col >= 6 and row >= 6, i.e. pixels x = 6..W-1 of lines y = 6..H-1.
  - Output frame is (W-6) x (H-6).
  - Pixels outside this region produce de_o = 0; the window still shifts.
- Bypass mode (bypass=1):
  - de_o = delayed de_i for every pixel (full W x H).
  - x24 = di_i delayed 2 clk.
  - Other x outputs are don't-care.
  - bypass is sampled per pixel; change it only during vertical blanking.
- Blanking: with no de_i, window registers hold their value, and de_o = 0.
- hs_o and vs_o are never gated (pure delays).
- Reset: all x outputs = 0, de_o = 0, hs_o = 1, vs_o = 0, col = 0, row = 0, pipeline cleared.
- Reset mid-frame: the first frame after reset release outputs no de_o until six complete lines of a new frame (vs_i low then high) have been received.
- Lines longer than LINE_SIZE_MAX: col wraps modulo LINE_SIZE_MAX. Output is undefined; no lockup is allowed.
- New frame (vs_i low to high): row restarts at 0, so stale lines from the previous frame never produce de_o.

Test Plan:
- 24x24 frame, di_i = x coordinate, DE_I_PERIOD=0, bypass=0 -> exactly 18 de_o per line on 18 lines (324 per frame). Each window row equals [x-6 .. x], e.g. the first valid window has every row 0,1,..,6. hs_o/vs_o equal hs_i/vs_i delayed 2 clk.
- Same frame with pixel value = 24*y + x -> first valid window has x00 = 0, x06 = 6, x42 = 144, x48 = 150, x24 = 75.
- DE_I_PERIOD=2 and 4 (gaps between pixels) -> identical window contents and de_o count as in the first case; de_o pulses mirror the de_i spacing.
- Two back-to-back frames -> second frame again has its first de_o on line 6, col 6, with no stale data from frame 1.
- bypass=1 -> 576 de_o per frame; x24 equals di_i delayed 2 clk.
- Assert rst mid-line in frame 1 -> outputs 0 and de_o low immediately. The next full frame behaves exactly as in the first case.
